// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns one EX/MEM request into word-memory port
// cycles, with big-endian sub-word lanes, load extension and RMW sub-word stores.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  misaligned,
  output logic [31:0]           load_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BADDR_W = ADDR_WIDTH + 2;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_EXT   = 3'd2,
    S_MERGE = 3'd3,
    S_WR    = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0]         op;
    logic [BADDR_W-1:0] addr;
    logic [DATA_W-1:0]  wdata;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q;
  logic              accept_c, misalign_c, is_load;
  logic [4:0]        byte_sh, half_sh;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] ext_c, merge_c;
  logic              unused_addr;

  // Byte-address bits above the memory size wrap away.
  assign unused_addr = ^req_addr[31:BADDR_W];

  assign accept_c = (state == S_IDLE) && req_valid;
  assign is_load  = (req_q.op <= OP_LBU);

  // Alignment check on the live request, evaluated only when accepted.
  always_comb begin
    misalign_c = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         misalign_c = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misalign_c = req_addr[0];
      default:              misalign_c = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if (accept_c) begin
      req_q <= '{op: req_op, addr: req_addr[BADDR_W-1:0], wdata: req_wdata};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid && !misalign_c) begin
          if (req_op == OP_SW) state_nxt = S_WR;
          else                 state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = is_load ? S_EXT : S_MERGE;
      S_EXT:   state_nxt = S_IDLE;
      S_MERGE: state_nxt = S_IDLE;
      S_WR:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Big-endian lanes: byte offset 0 is the most significant byte.
  assign byte_sh = {2'd3 - req_q.addr[1:0], 3'b000};
  assign half_sh = {~req_q.addr[1], 4'b0000};
  assign rd_byte = 8'(mem_rdata >> byte_sh);
  assign rd_half = 16'(mem_rdata >> half_sh);

  always_comb begin
    ext_c = mem_rdata;
    case (req_q.op)
      OP_LH:   ext_c = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ext_c = {16'h0000, rd_half};
      OP_LB:   ext_c = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ext_c = {24'h000000, rd_byte};
      default: ext_c = mem_rdata;
    endcase
  end

  always_comb begin
    if (req_q.op == OP_SH) begin
      merge_c = (mem_rdata & ~(32'h0000_FFFF << half_sh))
              | (32'(req_q.wdata[15:0]) << half_sh);
    end else begin
      merge_c = (mem_rdata & ~(32'h0000_00FF << byte_sh))
              | (32'(req_q.wdata[7:0]) << byte_sh);
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merge_c;
      end
      S_WR: begin
        mem_we    = 1'b1;
        mem_wdata = req_q.wdata;
      end
      default: ;
    endcase
  end

  assign mem_addr = req_q.addr[BADDR_W-1:2];

  // Completion pulse lands one cycle after the final state of each access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= '0;
    end else begin
      done       <= (accept_c && misalign_c) || (state == S_EXT)
                 || (state == S_MERGE) || (state == S_WR);
      misaligned <= accept_c && misalign_c;
      if (state == S_EXT) load_data <= ext_c;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level big-endian reference model,
// synchronous word memory, directed and randomized request streams.
module tb_load_store_unit;
  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, misaligned, mem_we;
  logic [31:0] load_data, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
    .misaligned(misaligned), .load_data(load_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        mis;
    logic [31:0] ld;
    int          lat;
    int          we;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_b [4096];
  logic [31:0] mem [1024];
  logic [31:0] last_ld = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          busy_cnt = 0;

  logic [2:0]  d_op [14] = '{OP_SW, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB,
                             OP_SB, OP_LW, OP_SH, OP_LW, OP_LW, OP_SH, OP_LW};
  logic [31:0] d_addr [14] = '{32'h10, 32'h10, 32'h11, 32'h11, 32'h12, 32'h12, 32'h13,
                               32'h12, 32'h10, 32'h10, 32'h10, 32'h13, 32'h11, 32'h10};
  logic [31:0] d_wd [14] = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0,
                             32'h00000055, 0, 32'hAAAA1234, 0, 0, 32'h5A5A5A5A, 0};

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous word memory: read data valid the cycle after the address.
  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: memory as a flat big-endian byte array, byte address mod 4096.
  task automatic predict(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output exp_t e);
    int a;
    a = int'(addr[11:0]);
    e.mis = (((op == OP_LW) || (op == OP_SW)) && (a % 4 != 0)) ||
            (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && (a % 2 != 0));
    e.lat = 0;
    e.we  = 0;
    e.due = 0;
    if (!e.mis) begin
      case (op)
        OP_LW:  begin last_ld = {ref_b[a], ref_b[a+1], ref_b[a+2], ref_b[a+3]}; e.lat = 2; end
        OP_LH:  begin last_ld = {{16{ref_b[a][7]}}, ref_b[a], ref_b[a+1]}; e.lat = 2; end
        OP_LHU: begin last_ld = {16'h0, ref_b[a], ref_b[a+1]}; e.lat = 2; end
        OP_LB:  begin last_ld = {{24{ref_b[a][7]}}, ref_b[a]}; e.lat = 2; end
        OP_LBU: begin last_ld = {24'h0, ref_b[a]}; e.lat = 2; end
        OP_SW: begin
          ref_b[a] = wd[31:24]; ref_b[a+1] = wd[23:16];
          ref_b[a+2] = wd[15:8]; ref_b[a+3] = wd[7:0];
          e.lat = 1; e.we = 1;
        end
        OP_SH: begin
          ref_b[a] = wd[15:8]; ref_b[a+1] = wd[7:0];
          e.lat = 2; e.we = 1;
        end
        default: begin
          ref_b[a] = wd[7:0];
          e.lat = 2; e.we = 1;
        end
      endcase
    end
    e.ld = last_ld;
  endtask

  // Called at a negedge with the unit idle (or in its done cycle); returns
  // at the negedge where done is seen. glitch scribbles on the request while busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input bit glitch);
    exp_t e;
    bit   seen;
    predict(op, addr, wd, e);
    e.due = cyc + 1 + e.lat;
    sb.push_back(e);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      else if (glitch && busy) begin
        req_valid = 1'($urandom); req_op = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done for op %0d addr 0x%08h", op, addr);
    end
  endtask

  // Monitor: pop and compare on every completion pulse.
  always @(negedge clock) begin
    if (reset) begin
      we_cnt = 0; busy_cnt = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done=1 with nothing outstanding at t=%0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.due));
          chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
          chk("load_data", load_data, e.ld);
          chk("we_cycles", 32'(we_cnt), 32'(e.we));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
        we_cnt = 0; busy_cnt = 0;
      end
      if (mem_we) we_cnt++;
      if (busy) busy_cnt++;
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, wd;
    int          bad;

    for (int i = 0; i < 4096; i++) ref_b[i] = 8'($urandom);
    for (int w = 0; w < 1024; w++)
      mem[w] = {ref_b[4*w], ref_b[4*w+1], ref_b[4*w+2], ref_b[4*w+3]};
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    #1 reset = 1'b0;
    @(negedge clock);

    // Directed sequence, issued back to back.
    for (int i = 0; i < 14; i++) begin
      run_op(d_op[i], d_addr[i], d_wd[i], (i == 1) || (i == 7));
      if (i == 1)  chk("spot_lw_deadbeef", load_data, 32'hDEADBEEF);
      if (i == 10) chk("spot_lw_merged", load_data, 32'h123455EF);
    end
    req_valid = 1'b0;
    @(negedge clock);

    // Abort an SB in its merge cycle with reset.
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h10; req_wdata = 32'h000000C3;
    @(negedge clock);
    @(negedge clock);
    chk("abort_in_merge_we", {31'b0, mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_load_data", load_data, 32'd0);
    chk("abort_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    req_valid = 1'b0;
    last_ld = '0;
    @(negedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_no_done", {31'b0, done}, 32'd0);
    end
    run_op(OP_LW, 32'h10, 32'h0, 1'b0);
    chk("abort_word_kept", load_data, 32'h123455EF);

    // Wrap: byte address 0x1000 aliases word 0.
    run_op(OP_SW, 32'h1000, 32'hCAFEF00D, 1'b0);
    run_op(OP_LW, 32'h0, 32'h0, 1'b0);
    chk("wrap_word0", load_data, 32'hCAFEF00D);
    req_valid = 1'b0;
    @(negedge clock);

    // Randomized stream in two small windows at both ends of memory.
    for (int n = 0; n < 400; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      a[11:0] = 12'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a[11:6] = 6'h3F;
      if ($urandom_range(0, 4) != 0) begin
        if ((op == OP_LW) || (op == OP_SW)) a[1:0] = 2'b00;
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) a[0] = 1'b0;
      end
      wd = $urandom;
      run_op(op, a, wd, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clock);
      end
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clock);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    bad = 0;
    for (int w = 0; w < 1024; w++)
      if (mem[w] !== {ref_b[4*w], ref_b[4*w+1], ref_b[4*w+2], ref_b[4*w+3]}) bad++;
    chk("memory_image_words_differing", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the word-wide synchronous data memory. It accepts one load/store request from the EX/MEM latch and converts it into memory port cycles. It handles word, halfword and byte accesses, with big-endian lane selection and sign/zero extension. Sub-word stores use a read-modify-write sequence. The block asserts `busy` so the pipeline control can hold the MEM stage while a multi-cycle access is in flight.

## Interface
- `ADDR_WIDTH`, 10, word-address bits driven to the memory (1024 words).

- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present; sampled only in IDLE.
- `req_op`  in  3  opcodes:
  - loads: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
  - stores: 101 SW, 110 SH, 111 SB
- `req_addr`  in  32  byte address (ALU result).
- `req_wdata`  in  32  store data; SH uses [15:0], SB uses [7:0].
- `busy`  out  1  state != IDLE (combinational from state).
- `done`  out  1  registered one-cycle completion pulse.
- `misaligned`  out  1  registered; valid with `done`.
- `load_data`  out  32  registered extended load result; holds until the next load completes.
- `mem_addr`  out  ADDR_WIDTH  word address = latched addr[ADDR_WIDTH+1:2].
- `mem_we`  out  1  memory write enable; decoded from state only.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid one cycle after `mem_addr` is sampled.

## Operation
- States:
  - IDLE: accept a request.
  - RD: read issued.
  - EXT: extract load data.
  - MERGE: sub-word write.
  - WR: full-word write.
- On an IDLE request, latch op, addr and wdata, then check alignment:
  - LW/SW need addr[1:0]=0.
  - LH/LHU/SH need addr[0]=0.
  - Misaligned: stay IDLE, next cycle `done`=1 and `misaligned`=1; no memory access.
- State transitions for aligned requests:
  - Loads: IDLE→RD→EXT→IDLE.
  - SW: IDLE→WR→IDLE.
  - SH/SB: IDLE→RD→MERGE→IDLE.
- Big-endian byte lanes:
  - Byte offsets 0/1/2/3 map to [31:24]/[23:16]/[15:8]/[7:0].
  - Halfword offsets 0/2 map to [31:16]/[15:0].
- EXT: select the lane from `mem_rdata`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through. Register the result into `load_data` on the EXT→IDLE edge.
- MERGE: `mem_wdata` = `mem_rdata` with only the target lane replaced by store data; `mem_we`=1.
- WR: `mem_wdata` = latched wdata; `mem_we`=1.
- `mem_we`=0 in every other state.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo memory size.
- `req_valid` while busy is ignored (not queued). The pipeline holds the request stable until `done`.

## Timing
- Edge 0 is the edge that accepts the request in IDLE. `done` is high in the cycle after the final edge:
  - SW: write at edge 1; `done` high after edge 1.
  - Loads: address sampled at edge 1; `load_data`/`done` after edge 2.
  - SH/SB: read at edge 1, merged write at edge 2; `done` after edge 2.
  - Misaligned: `done`/`misaligned` after edge 0.
- `done` and `misaligned` are high for exactly one cycle. `misaligned` is 0 on normal completions.
- A new request may be accepted in the same cycle `done` is high (IDLE), giving back-to-back operation.
- `mem_we` is high for exactly one cycle per store and never high for loads or misaligned requests.
- Reset values:
  - state IDLE
  - `busy`, `done`, `misaligned`, `mem_we` = 0
  - `load_data`, `mem_wdata`, `mem_addr` = 0
  - all latched request fields = 0
- Reset mid-operation: abort immediately. `mem_we` drops asynchronously with state, no partial or merged write completes, and no `done` is produced for the aborted request.

## Test plan
- Reset, SW 0xDEADBEEF @0x10, then LW @0x10 → word 4 = 0xDEADBEEF, `mem_we` one cycle, `load_data`=0xDEADBEEF; `done` at +1 and +2 cycles respectively.
- With word 4 = 0xDEADBEEF:
  - LB @0x11 → 0xFFFFFFAD; LBU @0x11 → 0x000000AD.
  - LH @0x12 → 0xFFFFBEEF; LHU @0x12 → 0x0000BEEF.
  - LB @0x13 → 0xFFFFFFEF.
- SB @0x12 wdata 0x00000055 → word 4 = 0xDEAD55EF. Then SH @0x10 wdata 0xAAAA1234 → 0x123455EF. `busy` is high for 2 cycles each; `mem_we` high only in MERGE.
- Misaligned cases:
  - LW @0x13 → `done`=`misaligned`=1 for one cycle, `mem_we` never high, `load_data` unchanged.
  - SH @0x11 → same response; memory unchanged.
- Assert `reset` during MERGE of SB @0x10 → `mem_we` falls immediately, word unchanged, all outputs at reset values, no `done`.
- Back-to-back and wrap:
  - Issue LW with `req_valid` asserted in the `done` cycle of a prior SW → accepted with no bubble.
  - Pulse `req_valid` while busy → ignored.
  - SW @0x1000 → writes word 0.
